// File: rtl/tff_ctrl_pkg.sv
// Shared encodings and next-count arithmetic for the T-flip-flop counter.
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_e;

    // Out-of-range counts (only reachable by corruption) recover to 0.
    function automatic logic [31:0] next_count(
        input logic [31:0] cnt,
        input logic        up,
        input logic [31:0] m
    );
        if (cnt >= m)
            return 32'd0;
        if (up)
            return (cnt == m - 32'd1) ? 32'd0 : cnt + 32'd1;
        return (cnt == 32'd0) ? m - 32'd1 : cnt - 32'd1;
    endfunction

    function automatic logic is_wrap(
        input logic [31:0] cnt,
        input logic        up,
        input logic [31:0] m
    );
        if (cnt >= m)
            return 1'b1;
        if (up)
            return cnt == m - 32'd1;
        return cnt == 32'd0;
    endfunction

endpackage

// File: rtl/tff_cell.sv
// One counter bit: a T flip-flop with asynchronous active-low reset.
module tff_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic T,
    output logic Q
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q ^ T;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q_q <= 1'b0;
        else
            q_q <= q_d;
    end

    assign Q = q_q;

endmodule

// File: rtl/tff_counter_ctrl.sv
// Run/pause/step controller sequencing a bank of T cells as a
// modulo-MOD up/down counter with prescaler and terminal-count pulse.
module tff_counter_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 10,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             up_dn,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state,
    output logic             running,
    output logic             tc
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    PSC_MAX = PW'(DIV - 1);
    localparam logic [31:0]      MOD32   = 32'(MOD);
    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MOD - 1);

    state_e           state_q, state_d;
    logic [PW-1:0]    psc_q, psc_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] nxt;
    logic             wrap;
    logic             adv;

    assign nxt  = WIDTH'(next_count(32'(cnt), up_dn, MOD32));
    assign wrap = is_wrap(32'(cnt), up_dn, MOD32);

    always_comb begin
        state_d = state_q;
        psc_d   = psc_q;
        target  = cnt;
        tc_d    = 1'b0;
        adv     = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            psc_d   = '0;
            target  = '0;
        end else if (load) begin
            psc_d  = '0;
            target = (32'(load_val) >= MOD32) ? TOP : load_val;
        end else if (stop) begin
            // Stop freezes count and prescaler; IDLE/PAUSE are unaffected.
            if (state_q == ST_RUN)
                state_d = ST_PAUSE;
        end else if (start && state_q != ST_RUN) begin
            state_d = ST_RUN;
            psc_d   = '0;
        end else if (state_q == ST_RUN) begin
            if (psc_q == PSC_MAX) begin
                psc_d = '0;
                adv   = 1'b1;
            end else begin
                psc_d = psc_q + 1'b1;
            end
        end else if (step) begin
            adv = 1'b1;
        end
        if (adv) begin
            target = nxt;
            tc_d   = wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            psc_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            psc_q   <= psc_d;
            tc_q    <= tc_d;
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk  (clk),
            .rst_n(rst_n),
            .T    (cnt[i] ^ target[i]),
            .Q    (cnt[i])
        );
    end

    assign count   = cnt;
    assign state   = state_q;
    assign running = (state_q == ST_RUN);
    assign tc      = tc_q;

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Scoreboard bench: expectations queued as commands are driven,
// popped and compared one cycle later on two parameterisations.
module tb_tff_counter_ctrl;

    localparam logic [1:0] I = 2'b00;
    localparam logic [1:0] R = 2'b01;
    localparam logic [1:0] P = 2'b10;

    typedef struct {
        logic [3:0] c;
        logic [1:0] s;
        logic       t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, stop = 1'b0, step = 1'b0;
    logic       clear = 1'b0, load = 1'b0, up_dn = 1'b1;
    logic [3:0] load_val = 4'd0;
    logic       sel = 1'b0;

    logic [3:0] cnt_a, cnt_b;
    logic [1:0] st_a, st_b;
    logic       run_a, run_b, tc_a, tc_b;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_tick = 0;

    always #5 clk = ~clk;

    tff_counter_ctrl #(.WIDTH(4), .MOD(10), .DIV(1)) u_a (
        .clk(clk), .rst_n(rst_n),
        .start(start & ~sel), .stop(stop & ~sel), .step(step & ~sel),
        .clear(clear & ~sel), .load(load & ~sel), .load_val(load_val),
        .up_dn(up_dn), .count(cnt_a), .state(st_a),
        .running(run_a), .tc(tc_a)
    );

    tff_counter_ctrl #(.WIDTH(4), .MOD(10), .DIV(3)) u_b (
        .clk(clk), .rst_n(rst_n),
        .start(start & sel), .stop(stop & sel), .step(step & sel),
        .clear(clear & sel), .load(load & sel), .load_val(load_val),
        .up_dn(up_dn), .count(cnt_b), .state(st_b),
        .running(run_b), .tc(tc_b)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic st, input logic sp, input logic sg,
                       input logic cl, input logic ld);
        start = st;
        stop  = sp;
        step  = sg;
        clear = cl;
        load  = ld;
    endtask

    task automatic tick(input logic [3:0] c, input logic [1:0] s,
                        input logic t);
        exp_t e;
        sb.push_back('{c: c, s: s, t: t});
        @(posedge clk);
        #1;
        n_tick++;
        e = sb.pop_front();
        check($sformatf("cnt@%0d", n_tick),
              sel ? cnt_b : cnt_a, 32'(e.c));
        check($sformatf("st@%0d", n_tick),
              sel ? st_b : st_a, 32'(e.s));
        check($sformatf("tc@%0d", n_tick),
              sel ? tc_b : tc_a, 32'(e.t));
        check($sformatf("run@%0d", n_tick),
              sel ? run_b : run_a, 32'(e.s == R));
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cnt"}, {cnt_a, cnt_b}, 0);
        check({tag, "_st"}, {st_a, st_b}, 0);
        check({tag, "_tc"}, {tc_a, tc_b}, 0);
        check({tag, "_run"}, {run_a, run_b}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] up_seq [12];
        up_seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        #12;
        check_reset("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Up count from reset, 12 advances with wrap.
        up_dn = 1'b1;
        cmd(1, 0, 0, 0, 0);
        tick(0, R, 0);
        cmd(0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++)
            tick(up_seq[i], R, up_seq[i] == 0);

        // Down count from 0.
        cmd(0, 0, 0, 1, 0);
        tick(0, I, 0);
        up_dn = 1'b0;
        cmd(1, 0, 0, 0, 0);
        tick(0, R, 0);
        cmd(0, 0, 0, 0, 0);
        tick(9, R, 1);
        tick(8, R, 0);
        tick(7, R, 0);

        // Stop on an advance edge freezes count; PAUSE stepping and load.
        up_dn = 1'b1;
        cmd(0, 1, 0, 0, 0);
        tick(7, P, 0);
        load_val = 4'd4;
        cmd(0, 0, 0, 0, 1);
        tick(4, P, 0);
        cmd(0, 0, 1, 0, 0);
        tick(5, P, 0);
        tick(6, P, 0);
        load_val = 4'd12;
        cmd(0, 0, 0, 0, 1);
        tick(9, P, 0);
        cmd(0, 0, 1, 0, 0);
        tick(0, P, 1);
        cmd(0, 0, 0, 0, 0);
        tick(0, P, 0);
        load_val = 4'd10;
        cmd(0, 0, 0, 0, 1);
        tick(9, P, 0);
        up_dn = 1'b0;
        cmd(0, 0, 1, 0, 0);
        tick(8, P, 0);
        up_dn = 1'b1;

        // Clear beats load in RUN; stop beats start.
        load_val = 4'd7;
        cmd(0, 0, 0, 0, 1);
        tick(7, P, 0);
        cmd(1, 0, 1, 0, 0);
        tick(7, R, 0);
        load_val = 4'd3;
        cmd(0, 0, 0, 1, 1);
        tick(0, I, 0);
        cmd(1, 1, 0, 0, 0);
        tick(0, I, 0);
        cmd(1, 0, 0, 0, 0);
        tick(0, R, 0);
        cmd(0, 0, 1, 0, 0);
        tick(1, R, 0);
        cmd(1, 1, 0, 0, 0);
        tick(1, P, 0);

        // Asynchronous reset mid-cycle from count 5 in RUN.
        cmd(1, 0, 0, 0, 0);
        tick(1, R, 0);
        cmd(0, 0, 0, 0, 0);
        for (int i = 2; i <= 5; i++)
            tick(4'(i), R, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("async_rst");
        #2;
        rst_n = 1'b1;
        tick(0, I, 0);
        tick(0, I, 0);
        tick(0, I, 0);

        // DIV = 3 instance: advances every third edge after start.
        sel = 1'b1;
        @(negedge clk);
        cmd(1, 0, 0, 0, 0);
        tick(0, R, 0);
        cmd(0, 0, 0, 0, 0);
        for (int e = 1; e <= 9; e++)
            tick(4'(e / 3), R, 0);
        cmd(0, 0, 0, 1, 0);
        tick(0, I, 0);
        cmd(1, 0, 0, 0, 0);
        tick(0, R, 0);
        cmd(0, 0, 0, 0, 0);
        tick(0, R, 0);
        tick(0, R, 0);
        tick(1, R, 0);
        tick(1, R, 0);
        cmd(0, 1, 0, 0, 0);
        tick(1, P, 0);
        cmd(0, 0, 0, 0, 0);
        tick(1, P, 0);
        tick(1, P, 0);
        cmd(1, 0, 0, 0, 0);
        tick(1, R, 0);
        cmd(0, 0, 0, 0, 0);
        tick(1, R, 0);
        tick(1, R, 0);
        tick(2, R, 0);

        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
